// File: rtl/sobel_window_buffer_pkg.sv
// Shared constants, pixel type and FSM encoding for the Sobel window buffer.
package sobel_window_buffer_pkg;
    localparam int unsigned MAX_PIXEL_BITS = 8;
    localparam int unsigned DEF_IMG_WIDTH  = 16;
    localparam int unsigned DEF_IMG_HEIGHT = 16;

    typedef logic [MAX_PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2
    } state_e;
endpackage

// File: rtl/sobel_window_buffer_if.sv
// Pixel-in / window-out signal bundle between the SPI receive stage and the Sobel core.
interface sobel_window_buffer_if
    import sobel_window_buffer_pkg::*;
#(
    parameter int unsigned PX_BITS = MAX_PIXEL_BITS
);
    logic [PX_BITS-1:0]   px_i;
    logic                 px_valid_i;
    logic                 frame_start_i;
    logic [9*PX_BITS-1:0] window_o;
    logic                 window_valid_o;
    logic                 frame_done_o;
    logic                 busy_o;

    modport master (
        output px_i, px_valid_i, frame_start_i,
        input  window_o, window_valid_o, frame_done_o, busy_o
    );

    modport slave (
        input  px_i, px_valid_i, frame_start_i,
        output window_o, window_valid_o, frame_done_o, busy_o
    );
endinterface

// File: rtl/sobel_window_buffer_line.sv
// One image line of pixel storage: combinational read of the addressed entry, write on the same edge.
module sobel_line_buffer
    import sobel_window_buffer_pkg::*;
#(
    parameter int unsigned PX_BITS = MAX_PIXEL_BITS,
    parameter int unsigned DEPTH   = DEF_IMG_WIDTH,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [AW-1:0]      i_addr,
    input  logic               i_we,
    input  logic [PX_BITS-1:0] i_wdata,
    output logic [PX_BITS-1:0] o_rdata
);
    logic [PX_BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/sobel_window_buffer.sv
// Two line buffers plus a 3x3 shift window; emits one window per interior pixel of a raster frame.
module sobel_window_buffer
    import sobel_window_buffer_pkg::*;
#(
    parameter int unsigned PX_BITS    = MAX_PIXEL_BITS,
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    sobel_window_buffer_if.slave  bus
);
    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_e             r_state;
    state_e             w_state_next;
    state_e             w_state_eff;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [CW-1:0]      w_col_eff;
    logic [RW-1:0]      w_row_eff;
    logic               w_accept;
    logic               w_col_last;
    logic               w_last_px;
    logic               w_window_valid_d;
    logic               w_frame_done_d;
    logic               r_window_valid;
    logic               r_frame_done;
    logic [PX_BITS-1:0] w_line0_rd;
    logic [PX_BITS-1:0] w_line1_rd;
    logic [PX_BITS-1:0] r_win [9];

    // frame_start_i clears position first, so a coincident pixel is taken as (0,0) from S_IDLE
    always_comb begin
        w_col_eff   = bus.frame_start_i ? '0 : r_col;
        w_row_eff   = bus.frame_start_i ? '0 : r_row;
        w_state_eff = bus.frame_start_i ? S_IDLE : r_state;
        w_accept    = bus.px_valid_i;
        w_col_last  = (w_col_eff == COL_LAST);
        w_last_px   = w_col_last && (w_row_eff == ROW_LAST);
    end

    sobel_line_buffer #(
        .PX_BITS (PX_BITS),
        .DEPTH   (IMG_WIDTH)
    ) u_line0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_addr  (w_col_eff),
        .i_we    (w_accept),
        .i_wdata (bus.px_i),
        .o_rdata (w_line0_rd)
    );

    sobel_line_buffer #(
        .PX_BITS (PX_BITS),
        .DEPTH   (IMG_WIDTH)
    ) u_line1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_addr  (w_col_eff),
        .i_we    (w_accept),
        .i_wdata (w_line0_rd),
        .o_rdata (w_line1_rd)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (w_row_eff == ROW_LAST) ? '0 : w_row_eff + 1'b1;
            end else begin
                r_col <= w_col_eff + 1'b1;
                r_row <= w_row_eff;
            end
        end else if (bus.frame_start_i) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_eff;
        if (w_accept) begin
            unique case (w_state_eff)
                S_IDLE:   w_state_next = S_FILL;
                S_FILL:   if (w_col_last && (w_row_eff == ROW_ONE)) w_state_next = S_STREAM;
                S_STREAM: if (w_last_px) w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_window_valid_d = w_accept && (w_row_eff >= ROW_TWO) && (w_col_eff >= COL_TWO);
        w_frame_done_d   = w_accept && (w_state_eff == S_STREAM) && w_last_px;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= w_window_valid_d;
            r_frame_done   <= w_frame_done_d;
        end
    end

    // Right column takes line values read before this edge's write: {line1, line0, new pixel}
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            for (int unsigned r = 0; r < 3; r++) begin
                r_win[r*3]     <= r_win[r*3 + 1];
                r_win[r*3 + 1] <= r_win[r*3 + 2];
            end
            r_win[2] <= w_line1_rd;
            r_win[5] <= w_line0_rd;
            r_win[8] <= bus.px_i;
        end
    end

    always_comb begin
        bus.window_o = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            bus.window_o[k*PX_BITS +: PX_BITS] = r_win[k];
        end
    end

    assign bus.window_valid_o = r_window_valid;
    assign bus.frame_done_o   = r_frame_done;
    assign bus.busy_o         = (r_state != S_IDLE);
endmodule
